bist_mem_responder: RTL and testbench

//   Memory-under-test model answering the STRAIT BIST engine's read/write requests, with

---
 rtl/bist_mem_responder.sv | 149 ++++++++++++++
 tb/tb_bist_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_mem_responder.sv
// ============================================================================
// Module      : bist_mem_responder
// Description : Memory-under-test model for the BIST engine. It supports
//               stuck-at and rising-transition fault injection and keeps
//               saturating traffic and fault-hit counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bist_mem_responder #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mem_req,
   input  logic                      mem_we,
   input  logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_wdata,
   output logic [DATA_W-1:0]         mem_rdata,
   output logic                      mem_rvalid,
   input  logic                      cfg_load,
   input  logic [1:0]                cfg_type,
   input  logic [ADDR_W-1:0]         cfg_addr,
   input  logic [$clog2(DATA_W)-1:0] cfg_bit,
   output logic                      fault_active,
   output logic [CNT_W-1:0]          wr_count,
   output logic [CNT_W-1:0]          rd_count,
   output logic [CNT_W-1:0]          hit_count
);

   localparam int         DEPTH   = 2 ** ADDR_W;
   localparam int         BIT_W   = $clog2(DATA_W);
   localparam logic [1:0] FT_NONE = 2'b00;
   localparam logic [1:0] FT_SA0  = 2'b01;
   localparam logic [1:0] FT_SA1  = 2'b10;
   localparam logic [1:0] FT_TFU  = 2'b11;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]        flt_type;
   logic [ADDR_W-1:0] flt_addr;
   logic [BIT_W-1:0]  flt_bit;

   logic              rd_fire;
   logic              wr_fire;
   logic [DATA_W-1:0] stored;
   logic [DATA_W-1:0] bit_mask;
   logic [DATA_W-1:0] rd_resolved;
   logic [DATA_W-1:0] wr_resolved;
   logic              rd_hit;
   logic              wr_hit;

   logic [RD_LAT-1:0] vld_pipe;
   logic [DATA_W-1:0] data_pipe [RD_LAT];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      return (en && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
   endfunction

   assign rd_fire = mem_req & ~mem_we;
   assign wr_fire = mem_req &  mem_we;

   // Faults are resolved against the currently latched config, before any same-cycle cfg_load.
   always_comb begin
      stored      = mem[mem_addr];
      bit_mask    = {{(DATA_W-1){1'b0}}, 1'b1} << flt_bit;
      rd_resolved = stored;
      wr_resolved = mem_wdata;
      rd_hit      = 1'b0;
      wr_hit      = 1'b0;
      if (mem_addr == flt_addr) begin
         case (flt_type)
            FT_SA0: begin
               rd_resolved = stored & ~bit_mask;
               rd_hit      = |(stored & bit_mask);
            end
            FT_SA1: begin
               rd_resolved = stored | bit_mask;
               rd_hit      = ~|(stored & bit_mask);
            end
            FT_TFU: begin
               if (|(mem_wdata & bit_mask & ~stored)) begin
                  wr_resolved = mem_wdata & ~bit_mask;
                  wr_hit      = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[mem_addr] <= wr_resolved;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flt_type <= FT_NONE;
         flt_addr <= '0;
         flt_bit  <= '0;
      end else if (cfg_load) begin
         flt_type <= cfg_type;
         flt_addr <= cfg_addr;
         flt_bit  <= cfg_bit;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            data_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[0] <= rd_fire;
         if (rd_fire) begin
            data_pipe[0] <= rd_resolved;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_count  <= '0;
         rd_count  <= '0;
         hit_count <= '0;
      end else begin
         wr_count  <= sat_inc(wr_count, wr_fire);
         rd_count  <= sat_inc(rd_count, rd_fire);
         hit_count <= sat_inc(hit_count, (rd_fire & rd_hit) | (wr_fire & wr_hit));
      end
   end

   assign mem_rvalid   = vld_pipe[RD_LAT-1];
   assign mem_rdata    = data_pipe[RD_LAT-1];
   assign fault_active = (flt_type != FT_NONE);

endmodule

`default_nettype wire

// File: tb/tb_bist_mem_responder.sv
// ============================================================================
// Module      : tb_bist_mem_responder
// Description : Scoreboard bench driving two responders (latency 1 / 16-bit
//               counters and latency 3 / 4-bit counters) with shared stimulus.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bist_mem_responder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_req = 1'b0;
   logic       mem_we = 1'b0;
   logic [3:0] mem_addr = '0;
   logic [7:0] mem_wdata = '0;
   logic       cfg_load = 1'b0;
   logic [1:0] cfg_type = '0;
   logic [3:0] cfg_addr = '0;
   logic [2:0] cfg_bit = '0;

   logic [7:0]  rdata1, rdata3;
   logic        rvalid1, rvalid3, fa1, fa3;
   logic [15:0] wr1, rd1, hit1;
   logic [3:0]  wr3, rd3, hit3;

   always #5 clk = ~clk;

   bist_mem_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_rvalid(rvalid1), .cfg_load(cfg_load),
      .cfg_type(cfg_type), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .fault_active(fa1),
      .wr_count(wr1), .rd_count(rd1), .hit_count(hit1));

   bist_mem_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .CNT_W(4)) dut3 (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(rdata3), .mem_rvalid(rvalid3), .cfg_load(cfg_load),
      .cfg_type(cfg_type), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .fault_active(fa3),
      .wr_count(wr3), .rd_count(rd3), .hit_count(hit3));

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q1[$];
   exp_t q3[$];

   // Reference memory and fault state
   logic [7:0] ref_mem [16];
   bit         known [16];
   int         m_type = 0, m_addr = 0, m_bit = 0;
   int         n_wr = 0, n_rd = 0, n_hit = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   // One request/config slot: drives the inputs and updates the reference model.
   task automatic issue(input bit req, input bit we, input int addr, input logic [7:0] wd,
                        input bit ld, input int ct, input int ca, input int cb);
      logic [7:0] v;
      exp_t       e;
      @(posedge clk); #1;
      mem_req = req; mem_we = we; mem_addr = addr[3:0]; mem_wdata = wd;
      cfg_load = ld; cfg_type = ct[1:0]; cfg_addr = ca[3:0]; cfg_bit = cb[2:0];
      if (req && we) begin
         v = wd;
         if (m_type == 3 && addr == m_addr && ref_mem[addr][m_bit] == 1'b0 && wd[m_bit] == 1'b1) begin
            v[m_bit] = 1'b0;
            n_hit++;
         end
         ref_mem[addr] = v;
         known[addr] = 1'b1;
         n_wr++;
      end else if (req) begin
         v = ref_mem[addr];
         if (addr == m_addr && m_type == 1) begin
            if (v[m_bit] != 1'b0) n_hit++;
            v[m_bit] = 1'b0;
         end
         if (addr == m_addr && m_type == 2) begin
            if (v[m_bit] != 1'b1) n_hit++;
            v[m_bit] = 1'b1;
         end
         n_rd++;
         e.data = v; e.due = cyc + 1; q1.push_back(e);
         e.due = cyc + 3;             q3.push_back(e);
      end
      if (ld) begin
         m_type = ct; m_addr = ca; m_bit = cb;
      end
   endtask

   task automatic wr(input int a, input logic [7:0] d); issue(1, 1, a, d, 0, 0, 0, 0); endtask
   task automatic rd(input int a);                      issue(1, 0, a, 8'h00, 0, 0, 0, 0); endtask
   task automatic cfg(input int t, input int a, input int b); issue(0, 0, 0, 8'h00, 1, t, a, b); endtask
   task automatic idle(input int n); for (int i = 0; i < n; i++) issue(0, 0, 0, 8'h00, 0, 0, 0, 0); endtask

   task automatic check_counters(input string tag);
      @(negedge clk);
      check({tag, "_wr1"},  wr1,  sat(n_wr, 16));
      check({tag, "_rd1"},  rd1,  sat(n_rd, 16));
      check({tag, "_hit1"}, hit1, sat(n_hit, 16));
      check({tag, "_fa1"},  fa1,  (m_type != 0));
      check({tag, "_wr3"},  wr3,  sat(n_wr, 4));
      check({tag, "_rd3"},  rd3,  sat(n_rd, 4));
      check({tag, "_hit3"}, hit3, sat(n_hit, 4));
      check({tag, "_fa3"},  fa3,  (m_type != 0));
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      reset = 1'b0; mem_req = 1'b0; cfg_load = 1'b0;
      q1.delete(); q3.delete();
      m_type = 0; m_addr = 0; m_bit = 0;
      n_wr = 0; n_rd = 0; n_hit = 0;
      for (int i = 0; i < 16; i++) known[i] = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      check("rst_rdata1", rdata1, 0);
      check("rst_rdata3", rdata3, 0);
      check_counters("rst");
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // Monitor: every cycle each DUT must either present the oldest expected read or stay idle.
   always @(negedge clk) begin
      exp_t e;
      if (q1.size() > 0 && q1[0].due == cyc) begin
         e = q1.pop_front();
         check("rvalid_lat1", rvalid1, 1);
         check("rdata_lat1", rdata1, e.data);
      end else begin
         check("idle_rvalid_lat1", rvalid1, 0);
      end
      if (q3.size() > 0 && q3[0].due == cyc) begin
         e = q3.pop_front();
         check("rvalid_lat3", rvalid3, 1);
         check("rdata_lat3", rdata3, e.data);
      end else begin
         check("idle_rvalid_lat3", rvalid3, 0);
      end
   end

   initial begin
      int r, a;
      do_reset(3);

      wr(3, 8'hA5); rd(3); idle(4);
      check_counters("nofault");

      cfg(1, 3, 0); wr(3, 8'hFF); rd(3); wr(4, 8'hFF); rd(4); idle(4);
      check_counters("sa0");

      cfg(2, 7, 7); wr(7, 8'h00); rd(7); cfg(0, 0, 0); rd(7); idle(4);
      check_counters("sa1");

      cfg(3, 2, 3); wr(2, 8'h00); wr(2, 8'h08); rd(2); wr(2, 8'hFF); rd(2); idle(4);
      check_counters("tfup");

      cfg(0, 0, 0);
      for (int i = 0; i < 4; i++) wr(i, 8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) rd(i);
      idle(5);
      rd(0); rd(1); rd(2);
      do_reset(2);
      idle(6);
      check_counters("post_reset");

      for (int i = 0; i < 8; i++) wr(i, 8'($urandom));
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         a = $urandom_range(0, 7);
         if (r <= 3 || (r <= 8 && !known[a]))
            wr(a, 8'($urandom));
         else if (r <= 7)
            rd(a);
         else if (r == 8)
            issue(1, 0, a, 8'h00, 1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         else
            idle(1);
      end
      idle(5);
      check_counters("random");
      check("q1_drained", q1.size(), 0);
      check("q3_drained", q3.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
